// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the N-lane pipeline controller.
package pipe_ctrl_pkg;

    localparam int MAX_LANES = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        RST_DRAIN = 2'd0,
        RUN       = 2'd1,
        RECOVER   = 2'd2
    } state_e;

    function automatic logic [MAX_LANES-1:0] lowest_set(input logic [MAX_LANES-1:0] v);
        return v & (~v + MAX_LANES'(1));
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_LANES-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_lane_pri.sv
// Lane-priority hazard and mispredict resolution; purely combinational.
module pipe_ctrl_lane_pri
    import pipe_ctrl_pkg::*;
#(
    parameter int LANES = 2,
    parameter int LW    = 1
) (
    input  logic [LANES-1:0] hzd_i,
    input  logic [LANES-1:0] mmem_i,
    input  logic [LANES-1:0] bj_en_i,
    input  logic [LANES-1:0] pre_taken_i,
    input  logic [LANES-1:0] bj_type_vld_i,
    input  logic             frz_i,
    input  logic             run_i,
    output logic [LANES-1:0] hzd_pfx_o,
    output logic [LANES-1:0] ex_blk_o,
    output logic [LANES-1:0] pm_eff_o,
    output logic [LANES-1:0] ex_pfx_o,
    output logic [LW-1:0]    pm_idx_o
);

    logic [LANES-1:0] blk;
    logic [LANES-1:0] older_blk;
    logic [LANES-1:0] bjv;
    logic [LANES-1:0] pm;
    logic             blk_acc;
    logic             hzd_acc;
    logic             pm_acc;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        blk       = hzd_i | mmem_i;
        older_blk = '0;
        hzd_pfx_o = '0;
        blk_acc   = 1'b0;
        hzd_acc   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            older_blk[i] = blk_acc;
            blk_acc      = blk_acc | blk[i];
            hzd_acc      = hzd_acc | hzd_i[i];
            hzd_pfx_o[i] = hzd_acc;
        end

        bjv = bj_en_i & ~hzd_i & ~older_blk;
        pm  = (bjv & ~pre_taken_i) | (~bjv & bj_type_vld_i & pre_taken_i);

        // Oldest mispredicting lane wins; nothing is accepted while frozen or outside RUN.
        pm_eff_o = '0;
        if (run_i && !frz_i) pm_eff_o = LANES'(lowest_set(MAX_LANES'(pm)));

        ex_pfx_o = '0;
        pm_acc   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            ex_pfx_o[i] = pm_acc;
            pm_acc      = pm_acc | pm_eff_o[i];
        end

        ex_blk_o = older_blk | blk;
    end

    assign pm_idx_o = LW'(onehot_to_idx(MAX_LANES'(pm_eff_o)));

endmodule

// File: rtl/pipe_ctrl_n.sv
// N-lane pipeline stall/flush controller with reset drain and mispredict recovery.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_n
    import pipe_ctrl_pkg::*;
#(
    parameter int  LANES     = 2,
    parameter int  RST_CYC   = 4,
    parameter int  RECOV_CYC = 2,
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LANES-1:0] dat_hzd_blk,
    input  logic [LANES-1:0] multi_mem_blk,
    input  logic             imiss_vld,
    input  logic             dmiss_vld,
    input  logic             io_blk,
    input  logic             buf_stl,
    input  logic [LANES-1:0] bj_en,
    input  logic [LANES-1:0] pre_taken,
    input  logic [LANES-1:0] bj_type_vld,
    output logic             freeze,
    output logic             fe_stl,
    output logic [LANES-1:0] data_blk,
    output logic [LANES-1:0] ex_fls,
    output logic             fe_de_fls,
    output logic             de_ex_fls,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      perf_frz_cyc,
    output logic [31:0]      perf_mispred,
`endif
    output logic             redirect_vld,
    output logic [LW-1:0]    redirect_lane
);

    localparam int CNT_MAX = (RST_CYC > RECOV_CYC) ? RST_CYC : RECOV_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             redirect_vld_q;
    logic [LW-1:0]    redirect_lane_q;

    logic             frz;
    logic             pm_any;
    logic [LANES-1:0] hzd_pfx;
    logic [LANES-1:0] ex_blk;
    logic [LANES-1:0] pm_eff;
    logic [LANES-1:0] ex_pfx;
    logic [LW-1:0]    pm_idx;

    assign frz    = imiss_vld | dmiss_vld | io_blk;
    assign pm_any = |pm_eff;

    pipe_ctrl_lane_pri #(
        .LANES (LANES),
        .LW    (LW)
    ) u_lane_pri (
        .hzd_i         (dat_hzd_blk),
        .mmem_i        (multi_mem_blk),
        .bj_en_i       (bj_en),
        .pre_taken_i   (pre_taken),
        .bj_type_vld_i (bj_type_vld),
        .frz_i         (frz),
        .run_i         (state_q == RUN),
        .hzd_pfx_o     (hzd_pfx),
        .ex_blk_o      (ex_blk),
        .pm_eff_o      (pm_eff),
        .ex_pfx_o      (ex_pfx),
        .pm_idx_o      (pm_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= RST_DRAIN;
            cnt_q           <= CW'(RST_CYC - 1);
            redirect_vld_q  <= 1'b0;
            redirect_lane_q <= '0;
        end else begin
            redirect_vld_q <= 1'b0;
            case (state_q)
                RST_DRAIN: begin
                    if (cnt_q == '0) state_q <= RUN;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                RUN: begin
                    if (pm_any) begin
                        state_q         <= RECOVER;
                        cnt_q           <= CW'(RECOV_CYC - 1);
                        redirect_vld_q  <= 1'b1;
                        redirect_lane_q <= pm_idx;
                    end
                end
                RECOVER: begin
                    // The recovery window is held open for as long as the pipe is frozen.
                    if (!frz) begin
                        if (cnt_q == '0) state_q <= RUN;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= RST_DRAIN;
                    cnt_q   <= CW'(RST_CYC - 1);
                end
            endcase
        end
    end

    always_comb begin
        freeze    = frz;
        fe_stl    = buf_stl | frz;
        data_blk  = hzd_pfx | {LANES{frz}};
        ex_fls    = (ex_blk & ~{LANES{frz}}) | ex_pfx;
        de_ex_fls = pm_any;
        fe_de_fls = pm_any;
        if (state_q == RST_DRAIN) begin
            fe_stl    = 1'b1;
            fe_de_fls = 1'b1;
            de_ex_fls = 1'b1;
            ex_fls    = '1;
        end else if (state_q == RECOVER) begin
            fe_de_fls = 1'b1;
        end
    end

    assign redirect_vld  = redirect_vld_q;
    assign redirect_lane = redirect_lane_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_frz_q;
    logic [31:0] perf_mis_q;
    logic [31:0] perf_frz_d;
    logic [31:0] perf_mis_d;

    always_comb begin
        perf_frz_d = perf_frz_q;
        perf_mis_d = perf_mis_q;
        if (frz && state_q != RST_DRAIN && perf_frz_q != 32'hFFFF_FFFF) perf_frz_d = perf_frz_q + 32'd1;
        if (pm_any && perf_mis_q != 32'hFFFF_FFFF)                      perf_mis_d = perf_mis_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_frz_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_frz_q <= perf_frz_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_frz_cyc = perf_frz_q;
    assign perf_mispred = perf_mis_q;
`endif

endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
- N-lane successor to the 2-lane pipeline controller; sits beside the issue/EX stages and drives stall, flush and data-block controls for fetch, decode, EX and MEM.
- Generalises the lane-priority hazard/branch-miss logic to LANES lanes.
- Adds sequential control: an internal reset-drain sequencer (replaces an external resetting-block input) and a multi-cycle mispredict recovery window with a registered redirect pulse.

Parameters:
- LANES, 2, issue lanes; lane 0 is oldest. Legal range 1..8.
- RST_CYC, 4, front-end drain cycles after reset release. Must be >= 1.
- RECOV_CYC, 2, extra front-end flush cycles after a mispredict flush cycle. Must be >= 1.
- LW, $clog2(LANES) (min 1), lane index width. Derived.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- dat_hzd_blk  in  LANES  per-lane data-hazard block.
- multi_mem_blk  in  LANES  per-lane multi-memory-op block.
- imiss_vld, dmiss_vld, io_blk  in  1 each  freeze sources.
- buf_stl  in  1  fetch buffer full.
- bj_en  in  LANES  branch resolved taken.
- pre_taken  in  LANES  predicted taken.
- bj_type_vld  in  LANES  lane holds a branch/jump.
- freeze  out  1  stall FE/DE, MEM-MEM2 and MEM2-WB.
- fe_stl  out  1  fetch stall.
- data_blk  out  LANES  per-lane data block.
- ex_fls  out  LANES  per-lane EX/MEM1 flush.
- fe_de_fls  out  1  FE/DE flush.
- de_ex_fls  out  1  DE/EX flush.
- redirect_vld  out  1  registered one-cycle redirect pulse.
- redirect_lane  out  LW  lane that caused the redirect.

Behaviour:
- Combinational terms:
  - blk[i] = hzd[i] | mmem[i]
  - frz = imiss | dmiss | io_blk
  - older_blk[i] = OR of blk[0..i-1] (0 for i=0)
  - bjv[i] = bj_en[i] & ~hzd[i] & ~older_blk[i]
  - pm[i] = (bjv[i] & ~pre_taken[i]) | (~bjv[i] & bj_type_vld[i] & pre_taken[i])
  - pm_eff = pm masked to its lowest set bit (oldest lane wins), forced to 0 when frz = 1 or state != RUN.
- FSM (state, cnt):
  - RST_DRAIN (reset value, cnt = RST_CYC-1):
    - fe_stl = 1, fe_de_fls = 1, de_ex_fls = 1, ex_fls = all ones.
    - Decrement cnt each cycle; at cnt = 0, go to RUN.
    - frz does not pause the drain.
  - RUN:
    - freeze = frz; fe_stl = buf_stl | frz.
    - data_blk[i] = OR hzd[0..i] | frz.
    - ex_fls[i] = (older_blk[i] | blk[i]) & ~frz | (OR pm_eff[0..i-1]).
    - de_ex_fls = |pm_eff; fe_de_fls = |pm_eff.
    - When |pm_eff: go to RECOVER with cnt = RECOV_CYC-1, and register redirect_vld = 1 and redirect_lane = index of pm_eff, both visible the next cycle.
  - RECOVER:
    - fe_de_fls = 1; all other outputs as in RUN, with pm_eff = 0.
    - Decrement cnt only when frz = 0; at cnt = 0 with frz = 0, go to RUN.
- redirect_vld is exactly one cycle, even when a freeze starts in the cycle it is registered. redirect_lane holds its last value while redirect_vld = 0.
- Reset outputs while reset is asserted: state/register-driven outputs forced to their RST_DRAIN values; redirect_vld = 0, redirect_lane = 0.
- Reset asserted mid-RECOVER: immediately back to RST_DRAIN with the full RST_CYC count.
- A mispredict arriving while frz = 1 is not accepted; the frozen EX stage re-presents the branch after the freeze.
- LANES = 1: older_blk and the ex_fls prefix term are 0; redirect_lane is 1 bit and always 0.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_frz_cyc[31:0] (cycles with frz = 1 in RUN/RECOVER) and perf_mispred[31:0] (accepted mispredicts).
  - Both are saturating at 32'hFFFF_FFFF and cleared by reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RST_DRAIN, RUN, RECOVER} (2 bits).
  - function lowest_set (one-hot of the lowest set bit).
  - function onehot_to_idx.
- One sub-module, pipe_ctrl_lane_pri: purely combinational, produces older_blk, bjv, pm, pm_eff one-hot and the ex_fls prefix terms. The top module keeps the FSM, counters and output registers.

Test Plan:
- Reset release, LANES=4, RST_CYC=4, all inputs 0 → fe_stl = fe_de_fls = 1, ex_fls = 4'hF for exactly 4 cycles; then fe_stl = 0, ex_fls = 0.
- RUN, hzd = 4'b0010 → data_blk = 4'b1110, ex_fls = 4'b1110; a mispredict on lane 2 is ignored (masked by older_blk).
- pm on lanes 1 and 3 together (bj_en = 0, pre_taken = bj_type_vld = 4'b1010) → ex_fls = 4'b1100, de_ex_fls = 1; next cycle redirect_vld = 1, redirect_lane = 1; fe_de_fls = 1 for 1 + RECOV_CYC cycles.
- During RECOVER (RECOV_CYC=2), dmiss_vld high for 3 cycles → window extended by 3 cycles; freeze = 1 and fe_stl = 1 during the miss; no second redirect.
- Mispredict condition present while imiss_vld = 1 → no flush and no redirect; when imiss drops, mispredict accepted the same cycle.
- With PIPE_CTRL_PERF_EN: 5 freeze cycles and 2 mispredicts → perf_frz_cyc = 5, perf_mispred = 2; preloaded at saturation, the counter stays at 32'hFFFF_FFFF.
